// File: rtl/cmd_arbiter.sv
// cmd_arbiter: read/write command arbiter with starvation guard feeding a single-entry output stage
module cmd_arbiter #(
  parameter int RD_STREAK_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] arid_i,
  input  logic [63:0] araddr_i,
  input  logic [7:0]  arlen_i,
  input  logic        arvalid_i,
  output logic        arready_o,
  input  logic [15:0] awid_i,
  input  logic [63:0] awaddr_i,
  input  logic [7:0]  awlen_i,
  input  logic        awvalid_i,
  output logic        awready_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [80:0] cmd_data_o,
  output logic [7:0]  cmd_len_o,
  output logic        busy_o
);
  localparam int SW = $clog2(RD_STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(RD_STREAK_MAX);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [80:0]   data_q, data_d;
  logic [7:0]    len_q, len_d;
  logic          free, gnt_rd, gnt_wr;
  // Grant selection; reads win a contest until the streak limit, and nothing is granted while held in reset
  always_comb begin
    free   = (state_q == EMPTY) || cmd_ready_i;
    gnt_rd = rst_n && free && arvalid_i && (!awvalid_i || streak_q < STREAK_MAX);
    gnt_wr = rst_n && free && awvalid_i && !gnt_rd;
  end
  // Next-state for stage occupancy, captured command and read streak
  always_comb begin
    state_d  = (gnt_rd || gnt_wr) ? FULL : (cmd_ready_i ? EMPTY : state_q);
    data_d   = gnt_rd ? {1'b0, arid_i, araddr_i} : (gnt_wr ? {1'b1, awid_i, awaddr_i} : data_q);
    len_d    = gnt_rd ? arlen_i : (gnt_wr ? awlen_i : len_q);
    streak_d = (!awvalid_i || gnt_wr) ? '0 :
               ((gnt_rd && streak_q != STREAK_MAX) ? streak_q + SW'(1) : streak_q);
  end
  // State register with asynchronous discard of any held command
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      streak_q <= '0;
      data_q   <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      data_q   <= data_d;
      len_q    <= len_d;
    end
  end
  assign arready_o   = gnt_rd;
  assign awready_o   = gnt_wr;
  assign cmd_valid_o = (state_q == FULL);
  assign cmd_data_o  = data_q;
  assign cmd_len_o   = len_q;
  assign busy_o      = cmd_valid_o || arvalid_i || awvalid_i;
endmodule

// File: tb/tb_cmd_arbiter.sv
// tb_cmd_arbiter: table-driven grant vectors with a command scoreboard for cmd_arbiter
module tb_cmd_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] arid_i = '0, awid_i = '0;
  logic [63:0] araddr_i = '0, awaddr_i = '0;
  logic [7:0]  arlen_i = '0, awlen_i = '0;
  logic        arvalid_i = 1'b0, awvalid_i = 1'b0, cmd_ready_i = 1'b0;
  logic        arready_o, awready_o, cmd_valid_o, busy_o;
  logic [80:0] cmd_data_o;
  logic [7:0]  cmd_len_o;
  int nvec = 0;
  int nerr = 0;
  logic [88:0] q[$];
  typedef struct packed {logic ar, aw, rdy, xar, xaw;} vec_t;
  vec_t tbl[27];

  cmd_arbiter #(.RD_STREAK_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i), .cmd_data_o(cmd_data_o), .cmd_len_o(cmd_len_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive one cycle, check mid-cycle, update scoreboard, advance to next negedge
  task automatic step(input logic ar, input logic aw, input logic rdy, input logic xar, input logic xaw,
                      input logic [15:0] rid, input logic [63:0] radr, input logic [7:0] rlen,
                      input logic [15:0] wid, input logic [63:0] wadr, input logic [7:0] wlen);
    arvalid_i = ar; awvalid_i = aw; cmd_ready_i = rdy;
    arid_i = rid; araddr_i = radr; arlen_i = rlen;
    awid_i = wid; awaddr_i = wadr; awlen_i = wlen;
    #1;
    check("arready", 128'(arready_o), 128'(xar));
    check("awready", 128'(awready_o), 128'(xaw));
    check("cmd_valid", 128'(cmd_valid_o), 128'(q.size() != 0));
    check("busy", 128'(busy_o), 128'(q.size() != 0 || ar || aw));
    if (cmd_valid_o && q.size() != 0) begin
      check("cmd", 128'({cmd_data_o, cmd_len_o}), 128'(q[0]));
      if (rdy) void'(q.pop_front());
    end
    if (xar) q.push_back({1'b0, rid, radr, rlen});
    if (xaw) q.push_back({1'b1, wid, wadr, wlen});
    @(negedge clk);
  endtask

  initial begin
    tbl = '{5'b10110, 5'b00100, 5'b01101, 5'b11000, 5'b11000, 5'b11000, 5'b11110,
            5'b11110, 5'b11110, 5'b11110, 5'b11101, 5'b11110, 5'b11110, 5'b11110,
            5'b11000, 5'b10110, 5'b11110, 5'b11110, 5'b11110, 5'b11110, 5'b11101,
            5'b00100, 5'b00100, 5'b01001, 5'b00000, 5'b10000, 5'b00100};
    arvalid_i = 1'b1; awvalid_i = 1'b1; cmd_ready_i = 1'b1;
    #1;
    check("rst_arready", 128'(arready_o), 128'(0));
    check("rst_awready", 128'(awready_o), 128'(0));
    check("rst_valid", 128'(cmd_valid_o), 128'(0));
    check("rst_data", 128'({cmd_data_o, cmd_len_o}), 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 27; i++)
      step(tbl[i].ar, tbl[i].aw, tbl[i].rdy, tbl[i].xar, tbl[i].xaw,
           16'(i), {32'hA0A0_0000, 32'(i)}, 8'(i),
           16'h8000 | 16'(i), {32'hB0B0_0000, 32'(i)}, 8'(255 - i));
    step(1, 0, 1, 1, 0, 16'h0007, 64'heeeeeeeeeeeeeeee, 8'd10, 16'h0, 64'h0, 8'h0);
    check("rd_exact", 128'({cmd_valid_o, cmd_data_o, cmd_len_o}),
          128'({1'b1, 1'b0, 16'h0007, 64'heeeeeeeeeeeeeeee, 8'd10}));
    step(0, 0, 1, 0, 0, 16'h0, 64'h0, 8'h0, 16'h0, 64'h0, 8'h0);
    step(0, 1, 1, 0, 1, 16'h0, 64'h0, 8'h0, 16'h0003, 64'h1000, 8'd0);
    check("wr_exact", 128'({cmd_valid_o, cmd_data_o, cmd_len_o}),
          128'({1'b1, 1'b1, 16'h0003, 64'h1000, 8'd0}));
    step(0, 0, 1, 0, 0, 16'h0, 64'h0, 8'h0, 16'h0, 64'h0, 8'h0);
    step(1, 0, 0, 1, 0, 16'h0055, 64'h1234, 8'd5, 16'h0, 64'h0, 8'h0);
    step(0, 0, 0, 0, 0, 16'h0, 64'h0, 8'h0, 16'h0, 64'h0, 8'h0);
    arvalid_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", 128'(cmd_valid_o), 128'(0));
    check("midrst_data", 128'({cmd_data_o, cmd_len_o}), 128'(0));
    check("midrst_arready", 128'(arready_o), 128'(0));
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1, 0, 0, 16'h0, 64'h0, 8'h0, 16'h0, 64'h0, 8'h0);
    step(0, 0, 1, 0, 0, 16'h0, 64'h0, 8'h0, 16'h0, 64'h0, 8'h0);
    check("post_rst_data", 128'({cmd_data_o, cmd_len_o}), 128'(0));
    check("sb_empty", 128'(q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
